// File: rtl/conf_int_mac_pipe_acc_pkg.sv
// Shared widths, pipeline sideband type and accumulator range helpers for the
// pipelined integer MAC.
package conf_int_mac_pkg;

    localparam int unsigned OP_W_DEF  = 16;
    localparam int unsigned ACC_W_DEF = 40;
    localparam int unsigned PIPE_DEF  = 2;
    localparam int unsigned LIM_W     = 128;

    // Per-element control that travels alongside the product.
    typedef struct packed {
        logic tc;
        logic last;
        logic sat_en;
        logic valid;
    } mac_side_t;

    // Range limits of a w-bit accumulator; callers truncate to w bits.
    function automatic logic [LIM_W-1:0] acc_smax(input int unsigned w);
        return (LIM_W'(1) << (w - 1)) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] acc_smin(input int unsigned w);
        return LIM_W'(1) << (w - 1);
    endfunction

    function automatic logic [LIM_W-1:0] acc_umax(input int unsigned w);
        return (LIM_W'(1) << w) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] acc_umin(input int unsigned w);
        return LIM_W'(w) & '0;
    endfunction

endpackage

// File: rtl/conf_int_mac_pipe_acc_if.sv
// Operand stream and result stream of the MAC, both valid/ready.
interface conf_int_mac_pipe_acc_if
    import conf_int_mac_pkg::*;
#(
    parameter int unsigned OP_W  = OP_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             tc;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_last, a, b, tc, sat_en, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );

    modport master (
        output in_valid, in_last, a, b, tc, sat_en, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/conf_int_mac_pipe_acc_mult_pipe.sv
// STAGES-deep signed/unsigned multiplier; the element's sideband rides along
// with its product and the whole pipe holds when en is low.
module conf_int_mult_pipe
    import conf_int_mac_pkg::*;
#(
    parameter int unsigned OP_W   = OP_W_DEF,
    parameter int unsigned STAGES = PIPE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_tc,
    input  logic              in_sat_en,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [2*OP_W-1:0] prod_o,
    output mac_side_t         side_o
);
    localparam int unsigned PW = 2 * OP_W;

    typedef struct packed {
        logic [PW-1:0] prod;
        mac_side_t     side;
    } stage_t;

    stage_t [STAGES-1:0] stage_q;
    stage_t [STAGES-1:0] stage_d;

    logic signed [PW-1:0] a_s;
    logic signed [PW-1:0] b_s;
    logic signed [PW-1:0] prod_s;
    logic        [PW-1:0] prod_u;

    // Both interpretations are formed; the element's tc picks one.
    always_comb begin : mult
        a_s    = PW'($signed(a));
        b_s    = PW'($signed(b));
        prod_s = a_s * b_s;
        prod_u = PW'(a) * PW'(b);
    end

    always_comb begin : stage_next
        stage_d = stage_q;
        if (en) begin
            stage_d              = stage_q << $bits(stage_t);
            stage_d[0].prod      = in_tc ? $unsigned(prod_s) : prod_u;
            stage_d[0].side.tc     = in_tc;
            stage_d[0].side.last   = in_last;
            stage_d[0].side.sat_en = in_sat_en;
            stage_d[0].side.valid  = in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : stage_regs
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign prod_o = stage_q[STAGES-1].prod;
    assign side_o = stage_q[STAGES-1].side;

endmodule

// File: rtl/conf_int_mac_pipe_acc.sv
// Pipelined multiply-accumulate: streams (a,b) pairs, emits one dot product per
// vector with optional saturation and a sticky overflow flag.
module conf_int_mac_pipe_acc
    import conf_int_mac_pkg::*;
#(
    parameter int unsigned OP_BITWIDTH  = OP_W_DEF,
    parameter int unsigned ACC_BITWIDTH = ACC_W_DEF,
    parameter int unsigned PIPE_STAGES  = PIPE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    conf_int_mac_pipe_acc_if.slave bus
);
    localparam int unsigned PW = 2 * OP_BITWIDTH;
    localparam int unsigned AW = ACC_BITWIDTH;
    localparam int unsigned SW = AW + 1;

    logic          en_c;
    logic [PW-1:0] m_prod;
    mac_side_t     m_side;

    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic [AW-1:0] out_data_q, out_data_d;
    logic          out_ovf_q, out_ovf_d;
    logic          out_valid_q, out_valid_d;

    logic [AW-1:0] base_acc;
    logic          base_ovf;
    logic [SW-1:0] ext_prod;
    logic [SW-1:0] ext_acc;
    logic [SW-1:0] sum;
    logic          elem_ovf;
    logic [AW-1:0] clamp;
    logic [AW-1:0] acc_new;

    // Only a held, unaccepted result stalls the datapath.
    assign en_c = ~(out_valid_q & ~bus.out_ready);

    conf_int_mult_pipe #(
        .OP_W   (OP_BITWIDTH),
        .STAGES (PIPE_STAGES)
    ) u_mult (
        .clk       (clk),
        .rst_n     (rst),
        .en        (en_c),
        .in_valid  (bus.in_valid),
        .in_last   (bus.in_last),
        .in_tc     (bus.tc),
        .in_sat_en (bus.sat_en),
        .a         (bus.a),
        .b         (bus.b),
        .prod_o    (m_prod),
        .side_o    (m_side)
    );

    // A completed vector leaves its total in acc_q for one cycle; the next
    // element starts from zero so back-to-back vectors need no bubble.
    always_comb begin : acc_math
        base_acc = done_q ? '0 : acc_q;
        base_ovf = done_q ? 1'b0 : ovf_q;
        if (m_side.tc) begin
            ext_prod = SW'($signed(m_prod));
            ext_acc  = SW'($signed(base_acc));
        end else begin
            ext_prod = SW'(m_prod);
            ext_acc  = SW'(base_acc);
        end
        sum = ext_acc + ext_prod;
        if (m_side.tc) begin
            elem_ovf = sum[SW-1] ^ sum[SW-2];
            clamp    = sum[SW-1] ? AW'(acc_smin(AW)) : AW'(acc_smax(AW));
        end else begin
            elem_ovf = sum[SW-1];
            clamp    = sum[SW-1] ? AW'(acc_umax(AW)) : AW'(acc_umin(AW));
        end
        acc_new = (elem_ovf & m_side.sat_en) ? clamp : sum[AW-1:0];
    end

    always_comb begin : acc_next
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        done_d      = done_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (en_c) begin
            acc_d       = m_side.valid ? acc_new : base_acc;
            ovf_d       = base_ovf | (m_side.valid & elem_ovf);
            done_d      = m_side.valid & m_side.last;
            // en_c implies any current result is being taken this edge.
            out_valid_d = done_q;
            if (done_q) begin
                out_data_d = acc_q;
                out_ovf_d  = ovf_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin : acc_regs
        if (!rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = en_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_conf_int_mac_pipe_acc.sv
// Directed bench for conf_int_mac_pipe_acc: a 40-bit and a 32-bit accumulator
// instance share the clock and reset.
module tb_conf_int_mac_pipe_acc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conf_int_mac_pipe_acc_if #(.OP_W(16), .ACC_W(40)) b40 ();
    conf_int_mac_pipe_acc_if #(.OP_W(16), .ACC_W(32)) b32 ();

    conf_int_mac_pipe_acc #(.OP_BITWIDTH(16), .ACC_BITWIDTH(40), .PIPE_STAGES(2)) u40 (
        .clk (clk), .rst (rst), .bus (b40.slave)
    );
    conf_int_mac_pipe_acc #(.OP_BITWIDTH(16), .ACC_BITWIDTH(32), .PIPE_STAGES(2)) u32 (
        .clk (clk), .rst (rst), .bus (b32.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [39:0] q40_d[$];
    logic        q40_o[$];
    int          q40_c[$];
    logic [31:0] q32_d[$];
    logic        q32_o[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result transfer; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst) begin
            if (b40.out_valid && b40.out_ready) begin
                q40_d.push_back(b40.out_data);
                q40_o.push_back(b40.out_ovf);
                q40_c.push_back(cyc);
            end
            if (b32.out_valid && b32.out_ready) begin
                q32_d.push_back(b32.out_data);
                q32_o.push_back(b32.out_ovf);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit w32, input logic [15:0] av, input logic [15:0] bv,
                        input logic tcv, input logic lastv, input logic satv);
        logic rdy;
        int   n;
        if (w32) begin
            b32.in_valid = 1'b1; b32.a = av; b32.b = bv;
            b32.tc = tcv; b32.in_last = lastv; b32.sat_en = satv;
        end else begin
            b40.in_valid = 1'b1; b40.a = av; b40.b = bv;
            b40.tc = tcv; b40.in_last = lastv; b40.sat_en = satv;
        end
        n = 0;
        do begin
            @(negedge clk);
            rdy = w32 ? b32.in_ready : b40.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) chk("send_timeout", 64'(rdy), 64'd1);
    endtask

    task automatic idle(input bit w32, input int n);
        if (w32) b32.in_valid = 1'b0;
        else     b40.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic get(input bit w32, input string tag, input logic [39:0] ed,
                       input logic eo, output int c);
        int n = 0;
        c = 0;
        while ((w32 ? q32_d.size() : q40_d.size()) == 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if ((w32 ? q32_d.size() : q40_d.size()) == 0) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else if (w32) begin
            chk({tag, "_data"}, 64'(q32_d.pop_front()), 64'(ed[31:0]));
            chk({tag, "_ovf"},  64'(q32_o.pop_front()), 64'(eo));
        end else begin
            c = q40_c.pop_front();
            chk({tag, "_data"}, 64'(q40_d.pop_front()), 64'(ed));
            chk({tag, "_ovf"},  64'(q40_o.pop_front()), 64'(eo));
        end
    endtask

    int c1, c2;

    initial begin
        rst = 1'b0;
        b40.in_valid = 1'b0; b40.a = '0; b40.b = '0; b40.tc = 1'b0;
        b40.in_last = 1'b0; b40.sat_en = 1'b0; b40.out_ready = 1'b1;
        b32.in_valid = 1'b0; b32.a = '0; b32.b = '0; b32.tc = 1'b0;
        b32.in_last = 1'b0; b32.sat_en = 1'b0; b32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(b40.out_valid), 64'd0);
        chk("rst_out_data",  64'(b40.out_data),  64'd0);
        chk("rst_out_ovf",   64'(b40.out_ovf),   64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(b40.in_ready), 64'd1);

        // Signed dot product 2*3 + (-4)*5 + 7*1 = -7, result after edge k+3
        send(0, 16'd2, 16'd3, 1'b1, 1'b0, 1'b0);
        send(0, 16'hFFFC, 16'd5, 1'b1, 1'b0, 1'b0);
        send(0, 16'd7, 16'd1, 1'b1, 1'b1, 1'b0);
        idle(0, 2);
        chk("lat_k2_valid", 64'(b40.out_valid), 64'd0);
        idle(0, 1);
        chk("lat_k3_valid", 64'(b40.out_valid), 64'd1);
        chk("lat_k3_data",  64'(b40.out_data),  64'h00_FFFF_FFFF_F9);
        get(0, "dot_signed", 40'hFF_FFFF_FFF9, 1'b0, c1);

        // Same bit pattern, unsigned vs signed
        send(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        idle(0, 1);
        get(0, "unsigned_ffff", 40'h00_FFFE_0001, 1'b0, c1);
        send(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        idle(0, 1);
        get(0, "signed_m1", 40'h00_0000_0001, 1'b0, c1);

        // 32-bit accumulator: saturate vs wrap, both flag overflow
        send(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        send(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        send(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        idle(1, 1);
        get(1, "sat_smax", 40'h00_7FFF_FFFF, 1'b1, c1);
        send(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        send(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0);
        send(1, 16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        idle(1, 1);
        get(1, "wrap", 40'h00_BFFD_0003, 1'b1, c1);
        send(1, 16'd1, 16'd1, 1'b1, 1'b1, 1'b0);
        idle(1, 1);
        get(1, "ovf_cleared", 40'h1, 1'b0, c1);
        send(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        send(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        idle(1, 1);
        get(1, "sat_umax", 40'h00_FFFF_FFFF, 1'b1, c1);
        send(1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        send(1, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        send(1, 16'h8000, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        idle(1, 1);
        get(1, "sat_smin", 40'h00_8000_0000, 1'b1, c1);

        // Back-pressure: ten single-element vectors with the output blocked
        fork
            begin
                for (int i = 0; i < 10; i++) send(0, 16'(i), 16'(i), 1'b0, 1'b1, 1'b0);
                idle(0, 1);
            end
            begin
                repeat (4) begin
                    @(posedge clk);
                    #1;
                end
                b40.out_ready = 1'b0;
                #1;
                chk("bp_in_ready_low", 64'(b40.in_ready), 64'd0);
                repeat (6) begin
                    @(posedge clk);
                    #1;
                end
                chk("bp_hold_valid", 64'(b40.out_valid), 64'd1);
                chk("bp_hold_data",  64'(b40.out_data),  64'd0);
                b40.out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 10; i++) get(0, "bp_result", 40'(i * i), 1'b0, c1);
        idle(0, 5);
        chk("bp_no_dup", 64'(q40_d.size()), 64'd0);

        // Asynchronous reset while a result is held and a vector is in flight
        b40.out_ready = 1'b0;
        send(0, 16'd6, 16'd6, 1'b0, 1'b1, 1'b0);
        send(0, 16'd3, 16'd3, 1'b0, 1'b0, 1'b0);
        send(0, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0);
        idle(0, 2);
        chk("rst_pre_valid", 64'(b40.out_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_valid", 64'(b40.out_valid), 64'd0);
        chk("rst_async_data",  64'(b40.out_data),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        b40.out_ready = 1'b1;
        send(0, 16'd5, 16'd5, 1'b0, 1'b1, 1'b0);
        idle(0, 1);
        get(0, "post_rst", 40'd25, 1'b0, c1);

        // Bubble inside a vector, then back-to-back vectors
        send(0, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0);
        idle(0, 1);
        send(0, 16'd2, 16'd2, 1'b0, 1'b1, 1'b0);
        send(0, 16'd3, 16'd3, 1'b0, 1'b1, 1'b0);
        idle(0, 1);
        get(0, "bubble_v1", 40'd5, 1'b0, c1);
        get(0, "bubble_v2", 40'd9, 1'b0, c2);
        chk("b2b_gap", 64'(c2 - c1), 64'd1);

        idle(0, 5);
        chk("queues_empty", 64'(q40_d.size() + q32_d.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
